// File: rtl/cnn_sched_pkg.sv
// cnn_sched_pkg: scheduler FSM states, DMA target selects and descriptor layout
package cnn_sched_pkg;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] CMD  = 3'd2;
  localparam logic [2:0] KICK = 3'd3;
  localparam logic [2:0] RUN  = 3'd4;
  localparam logic [2:0] NEXT = 3'd5;
  localparam logic [2:0] DONE = 3'd6;
  localparam logic [2:0] ERR  = 3'd7;
  localparam logic [1:0] SEL_IFM = 2'd0;
  localparam logic [1:0] SEL_WGT = 2'd1;
  localparam logic [1:0] SEL_OFM = 2'd2;
  localparam int DESC_CNT_W = 16;
  typedef struct packed {
    logic [DESC_CNT_W-1:0] ofm_beats;
    logic [DESC_CNT_W-1:0] wgt_beats;
    logic [DESC_CNT_W-1:0] ifm_beats;
  } desc_t;
endpackage

// File: rtl/cnn_desc_table.sv
// cnn_desc_table: layer descriptor RAM, synchronous write and 1-cycle synchronous read
module cnn_desc_table #(
  parameter int DEPTH = 16,
  parameter int W = 48
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cnn_layer_scheduler.sv
// cnn_layer_scheduler: walks the descriptor table, issuing DMA commands and accelerator starts per layer
module cnn_layer_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int MAX_LAYERS = 16,
  parameter int CNT_W = 16,
  parameter int TIMEOUT_W = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
  input  logic [3*CNT_W-1:0]            cfg_data,
  input  logic                          start,
  input  logic [$clog2(MAX_LAYERS):0]   num_layers,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(MAX_LAYERS)-1:0] cur_layer,
  output logic                          acc_start,
  input  logic                          acc_done,
  input  logic                          ifm_fire,
  input  logic                          wgt_fire,
  input  logic                          ofm_fire,
  output logic                          dma_cmd_valid,
  input  logic                          dma_cmd_ready,
  output logic [1:0]                    dma_cmd_sel,
  output logic [CNT_W-1:0]              dma_cmd_len
);
  localparam int AW = $clog2(MAX_LAYERS);
  localparam logic [AW:0] MAXL = (AW+1)'(MAX_LAYERS);
  logic [2:0] state, nxt;
  logic [AW:0] nl;
  logic [AW-1:0] rd_addr;
  logic [3*CNT_W-1:0] rd_data;
  logic [CNT_W-1:0] ifm_len, wgt_len, ofm_len;
  logic [CNT_W-1:0] ifm_cnt, wgt_cnt, ofm_cnt;
  logic [CNT_W-1:0] ifm_nxt, wgt_nxt, ofm_nxt;
  logic [TIMEOUT_W-1:0] wd, wd_inc;
  logic [1:0] cmd_idx, cur;
  logic [2:0] pend, rest;
  logic flag, counting, ovf, all_met, active, wd_hit, last_layer;
  cnn_desc_table #(.DEPTH(MAX_LAYERS), .W(3*CNT_W)) u_table (
    .clk(clk),
    .we(cfg_we && state == IDLE),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
  // datapath decode: table address, pending commands, beat accounting, watchdog
  always_comb begin
    rd_addr = state == NEXT ? cur_layer + 1'b1 : state == IDLE ? '0 : cur_layer;
    pend = {cmd_idx <= 2'd2 && ofm_len != '0, cmd_idx <= 2'd1 && wgt_len != '0, cmd_idx == 2'd0 && ifm_len != '0};
    rest = pend & (pend - 3'd1);
    cur = pend[0] ? SEL_IFM : pend[1] ? SEL_WGT : SEL_OFM;
    dma_cmd_valid = state == CMD && |pend;
    dma_cmd_sel = dma_cmd_valid ? cur : 2'd0;
    dma_cmd_len = !dma_cmd_valid ? '0 : pend[0] ? ifm_len : pend[1] ? wgt_len : ofm_len;
    counting = state == CMD || state == KICK || state == RUN;
    ovf = counting && ((ifm_fire && ifm_cnt == ifm_len) || (wgt_fire && wgt_cnt == wgt_len) || (ofm_fire && ofm_cnt == ofm_len));
    ifm_nxt = ifm_cnt + {{(CNT_W-1){1'b0}}, ifm_fire};
    wgt_nxt = wgt_cnt + {{(CNT_W-1){1'b0}}, wgt_fire};
    ofm_nxt = ofm_cnt + {{(CNT_W-1){1'b0}}, ofm_fire};
    all_met = ifm_nxt == ifm_len && wgt_nxt == wgt_len && ofm_nxt == ofm_len;
    active = ifm_fire || wgt_fire || ofm_fire || acc_done;
    wd_inc = wd + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    wd_hit = !active && wd_inc == '1;
    last_layer = {1'b0, cur_layer} + 1'b1 == nl;
    busy = state != IDLE && state != DONE && state != ERR;
    done = state == DONE;
    acc_start = state == KICK;
  end
  // next-state selection
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !start ? IDLE : num_layers == '0 ? DONE : LOAD;
      LOAD: nxt = CMD;
      CMD:  nxt = ovf ? ERR : (!(|pend) || (dma_cmd_ready && rest == 3'd0)) ? KICK : CMD;
      KICK: nxt = ovf ? ERR : RUN;
      RUN:  nxt = (ovf || wd_hit) ? ERR : ((flag || acc_done) && all_met) ? NEXT : RUN;
      NEXT: nxt = last_layer ? DONE : LOAD;
      default: nxt = IDLE;
    endcase
  end
  // state, run bookkeeping, per-layer descriptor and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      error <= 1'b0;
      cur_layer <= '0;
      nl <= '0;
      cmd_idx <= 2'd0;
      flag <= 1'b0;
      wd <= '0;
      ifm_len <= '0;
      wgt_len <= '0;
      ofm_len <= '0;
      ifm_cnt <= '0;
      wgt_cnt <= '0;
      ofm_cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start && num_layers != '0) begin
        error <= 1'b0;
        cur_layer <= '0;
        nl <= num_layers > MAXL ? MAXL : num_layers;
      end
      if (nxt == ERR) error <= 1'b1;
      if (state == NEXT && !last_layer) cur_layer <= cur_layer + 1'b1;
      if (state == LOAD) begin
        ifm_len <= rd_data[CNT_W-1:0];
        wgt_len <= rd_data[2*CNT_W-1:CNT_W];
        ofm_len <= rd_data[3*CNT_W-1:2*CNT_W];
        ifm_cnt <= '0;
        wgt_cnt <= '0;
        ofm_cnt <= '0;
        cmd_idx <= 2'd0;
        flag <= 1'b0;
        wd <= '0;
      end
      if (counting && !ovf) begin
        ifm_cnt <= ifm_nxt;
        wgt_cnt <= wgt_nxt;
        ofm_cnt <= ofm_nxt;
      end
      if (dma_cmd_valid && dma_cmd_ready) cmd_idx <= cur + 2'd1;
      if (state == RUN) begin
        flag <= flag || acc_done;
        wd <= active ? '0 : wd_inc;
      end
    end
  end
endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// tb_cnn_layer_scheduler: directed scenario bench for the layer scheduler
module tb_cnn_layer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [47:0] cfg_data = '0;
  logic start = 1'b0;
  logic [4:0] num_layers = '0;
  logic acc_done = 1'b0;
  logic ifm_fire = 1'b0;
  logic wgt_fire = 1'b0;
  logic ofm_fire = 1'b0;
  logic dma_cmd_ready = 1'b0;
  logic busy, done, error, acc_start, dma_cmd_valid;
  logic [3:0] cur_layer;
  logic [1:0] dma_cmd_sel;
  logic [15:0] dma_cmd_len;
  int checks = 0;
  int failures = 0;
  int n_start = 0;
  int n_done = 0;
  int n_valid = 0;
  int n_cmd = 0;
  logic [17:0] cmd_log [64];

  cnn_layer_scheduler #(.MAX_LAYERS(16), .CNT_W(16), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .num_layers(num_layers), .busy(busy), .done(done), .error(error),
    .cur_layer(cur_layer), .acc_start(acc_start), .acc_done(acc_done),
    .ifm_fire(ifm_fire), .wgt_fire(wgt_fire), .ofm_fire(ofm_fire),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_sel(dma_cmd_sel), .dma_cmd_len(dma_cmd_len)
  );

  always #5 clk = ~clk;

  // pulse counters and accepted-command log, sampled mid-cycle
  always @(negedge clk) begin
    if (acc_start) n_start++;
    if (done) n_done++;
    if (dma_cmd_valid) n_valid++;
    if (dma_cmd_valid && dma_cmd_ready && n_cmd < 64) begin
      cmd_log[n_cmd] = {dma_cmd_sel, dma_cmd_len};
      n_cmd++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] o, input logic [15:0] w, input logic [15:0] i);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_data = {o, w, i};
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [4:0] n);
    num_layers = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_kick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (acc_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_acc_start: no acc_start within 60 cycles");
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_done: no done within 60 cycles");
    end
  endtask

  task automatic beats(input int ni, input int nw, input int no);
    for (int k = 0; k < ni || k < nw || k < no; k++) begin
      ifm_fire = k < ni;
      wgt_fire = k < nw;
      ofm_fire = k < no;
      tick();
    end
    ifm_fire = 1'b0;
    wgt_fire = 1'b0;
    ofm_fire = 1'b0;
  endtask

  task automatic finish_layer(input int ni, input int nw, input int no);
    wait_kick();
    tick();
    beats(ni, nw, no);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({busy, done, error, acc_start, dma_cmd_valid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000", {busy, done, error, acc_start, dma_cmd_valid});
    end
    checks++;
    if (cur_layer !== 4'd0) begin
      failures++;
      $display("FAIL reset_cur_layer: got %0d want 0", cur_layer);
    end
    checks++;
    if ({dma_cmd_sel, dma_cmd_len} !== 18'd0) begin
      failures++;
      $display("FAIL reset_cmd: got sel=%0d len=%0d want 0 0", dma_cmd_sel, dma_cmd_len);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_two_layers();
    int s0, d0, c0;
    logic [17:0] exp [5];
    exp = '{{2'd0, 16'd4}, {2'd1, 16'd2}, {2'd2, 16'd3}, {2'd0, 16'd8}, {2'd2, 16'd1}};
    wr(4'd0, 16'd3, 16'd2, 16'd4);
    wr(4'd1, 16'd1, 16'd0, 16'd8);
    dma_cmd_ready = 1'b1;
    s0 = n_start;
    d0 = n_done;
    c0 = n_cmd;
    go(5'd2);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL two_busy: got %b want 1", busy);
    end
    finish_layer(4, 2, 3);
    finish_layer(8, 0, 1);
    wait_done();
    tick();
    checks++;
    if (n_cmd - c0 !== 5) begin
      failures++;
      $display("FAIL two_cmd_count: got %0d want 5", n_cmd - c0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_log[c0 + i] !== exp[i]) begin
        failures++;
        $display("FAIL two_cmd%0d: got sel=%0d len=%0d want sel=%0d len=%0d", i,
                 cmd_log[c0 + i][17:16], cmd_log[c0 + i][15:0], exp[i][17:16], exp[i][15:0]);
      end
    end
    checks++;
    if (n_start - s0 !== 2) begin
      failures++;
      $display("FAIL two_acc_start: got %0d pulses want 2", n_start - s0);
    end
    checks++;
    if (n_done - d0 !== 1) begin
      failures++;
      $display("FAIL two_done: got %0d pulses want 1", n_done - d0);
    end
    checks++;
    if ({error, busy} !== 2'b00) begin
      failures++;
      $display("FAIL two_end_flags: got error=%b busy=%b want 0 0", error, busy);
    end
  endtask

  task automatic test_late_done();
    wr(4'd0, 16'd3, 16'd1, 16'd1);
    go(5'd1);
    wait_kick();
    tick();
    ifm_fire = 1'b1;
    wgt_fire = 1'b1;
    ofm_fire = 1'b1;
    tick();
    ifm_fire = 1'b0;
    wgt_fire = 1'b0;
    acc_done = 1'b1;
    tick();
    ofm_fire = 1'b0;
    acc_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b01) begin
      failures++;
      $display("FAIL late_hold: got done=%b busy=%b want 0 1", done, busy);
    end
    tick();
    ofm_fire = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL late_last_beat: got done=%b want 0", done);
    end
    tick();
    ofm_fire = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b01) begin
      failures++;
      $display("FAIL late_next: got done=%b busy=%b want 0 1", done, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({done, busy, error} !== 3'b100) begin
      failures++;
      $display("FAIL late_done: got done=%b busy=%b error=%b want 1 0 0", done, busy, error);
    end
    tick();
  endtask

  task automatic test_overflow();
    int d0;
    wr(4'd0, 16'd3, 16'd2, 16'd4);
    wr(4'd1, 16'd3, 16'd2, 16'd4);
    d0 = n_done;
    go(5'd2);
    finish_layer(4, 2, 3);
    wait_kick();
    tick();
    beats(5, 2, 3);
    @(negedge clk);
    checks++;
    if ({error, busy, done} !== 3'b100) begin
      failures++;
      $display("FAIL ovf_flags: got error=%b busy=%b done=%b want 1 0 0", error, busy, done);
    end
    checks++;
    if (cur_layer !== 4'd1) begin
      failures++;
      $display("FAIL ovf_cur_layer: got %0d want 1", cur_layer);
    end
    repeat (3) tick();
    checks++;
    if (n_done - d0 !== 0) begin
      failures++;
      $display("FAIL ovf_no_done: got %0d done pulses want 0", n_done - d0);
    end
    checks++;
    if ({error, busy} !== 2'b10) begin
      failures++;
      $display("FAIL ovf_sticky: got error=%b busy=%b want 1 0", error, busy);
    end
  endtask

  task automatic test_watchdog();
    wr(4'd0, 16'd3, 16'd2, 16'd4);
    go(5'd1);
    @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL wd_error_cleared: got %b want 0", error);
    end
    wait_kick();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) begin
        checks++;
        if ({error, busy} !== 2'b01) begin
          failures++;
          $display("FAIL wd_before: got error=%b busy=%b want 0 1", error, busy);
        end
      end
      if (k == 16) begin
        checks++;
        if ({error, busy} !== 2'b10) begin
          failures++;
          $display("FAIL wd_fire: got error=%b busy=%b want 1 0", error, busy);
        end
      end
    end
    tick();
  endtask

  task automatic test_zero_layers();
    int s0, v0;
    s0 = n_start;
    v0 = n_valid;
    go(5'd0);
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_one_pulse: got done=%b want 0", done);
    end
    tick();
    checks++;
    if (n_start - s0 !== 0 || n_valid - v0 !== 0) begin
      failures++;
      $display("FAIL zero_quiet: got acc_start=%0d cmd_valid=%0d want 0 0", n_start - s0, n_valid - v0);
    end
  endtask

  task automatic test_stall_reset();
    bit seen;
    bit bad;
    int c0;
    dma_cmd_ready = 1'b0;
    wr(4'd0, 16'd3, 16'd2, 16'd4);
    go(5'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dma_cmd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL stall_valid: got no dma_cmd_valid within 10 cycles want valid");
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({dma_cmd_valid, dma_cmd_sel, dma_cmd_len} !== {1'b1, 2'd0, 16'd4}) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold: got unstable command want valid sel=0 len=4 held");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({dma_cmd_valid, dma_cmd_len} !== {1'b1, 16'd4}) begin
      failures++;
      $display("FAIL stall_pre_reset: got valid=%b len=%0d want 1 4", dma_cmd_valid, dma_cmd_len);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({busy, done, error, acc_start, dma_cmd_valid, cur_layer, dma_cmd_sel, dma_cmd_len} !== 27'd0) begin
      failures++;
      $display("FAIL stall_post_reset: got busy=%b done=%b error=%b start=%b valid=%b layer=%0d sel=%0d len=%0d want all 0",
               busy, done, error, acc_start, dma_cmd_valid, cur_layer, dma_cmd_sel, dma_cmd_len);
    end
    rst = 1'b0;
    tick();
    dma_cmd_ready = 1'b1;
    wr(4'd0, 16'd1, 16'd1, 16'd2);
    c0 = n_cmd;
    go(5'd1);
    finish_layer(2, 1, 1);
    wait_done();
    tick();
    checks++;
    if (n_cmd - c0 !== 3 || cmd_log[c0] !== {2'd0, 16'd2}) begin
      failures++;
      $display("FAIL cfg_after_reset: got cmds=%0d first sel=%0d len=%0d want 3 0 2",
               n_cmd - c0, cmd_log[c0][17:16], cmd_log[c0][15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_two_layers();
    test_late_done();
    test_overflow();
    test_watchdog();
    test_zero_layers();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cnn_layer_scheduler.md
Name: cnn_layer_scheduler

Overview:
Sequences cnn_accelerator across a multi-layer network (e.g. a MobileNet run).
- Holds a small layer-descriptor table.
- Per layer: issues stream-DMA commands, pulses the accelerator start, counts IFM/weight/OFM beats by tapping the stream handshakes, waits for the accelerator done, then advances.
- Sits between the host/config bus and the accelerator plus its stream DMAs.

Parameters:
- MAX_LAYERS, 16: descriptor table depth.
- CNT_W, 16: width of each beat count (64-bit beats).
- TIMEOUT_W, 24: width of the stall watchdog counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  descriptor write strobe.
- cfg_addr  in  $clog2(MAX_LAYERS)  descriptor index.
- cfg_data  in  3*CNT_W  {ofm_beats, wgt_beats, ifm_beats}, ifm_beats in the LSBs.
- start  in  1  begin a run.
- num_layers  in  $clog2(MAX_LAYERS)+1  number of layers to run; sampled on start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag.
- cur_layer  out  $clog2(MAX_LAYERS)  layer being executed, or the failing layer.
- acc_start  out  1  one-cycle start pulse to the accelerator.
- acc_done  in  1  accelerator done pulse/level.
- ifm_fire  in  1  ifm_valid&ifm_ready tap.
- wgt_fire  in  1  weight_valid&weight_ready tap.
- ofm_fire  in  1  ofm_valid&ofm_ready tap.
- dma_cmd_valid  out  1  DMA command valid.
- dma_cmd_ready  in  1  DMA command accept.
- dma_cmd_sel  out  2  target: 0=IFM, 1=WGT, 2=OFM.
- dma_cmd_len  out  CNT_W  beat count for the command.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; table contents undefined.
- cfg writes take effect only in IDLE and are ignored otherwise. Table is synchronous-read, 1-cycle latency.
- IDLE:
  - start with num_layers==0 → done pulse next cycle; no acc_start.
  - start with num_layers>MAX_LAYERS → clamp to MAX_LAYERS.
  - otherwise clear error, cur_layer=0, go to LOAD; busy=1 from the next cycle.
  - start while not IDLE is ignored.
- LOAD (1 cycle): latch the descriptor for cur_layer; clear the three beat counters and the acc_done flag → CMD.
- CMD: issue IFM, WGT, OFM commands in order.
  - dma_cmd_valid is held with sel/len stable until dma_cmd_ready.
  - Commands with len 0 are skipped with no valid asserted, for zero cycles.
  - After the last command → KICK.
- KICK (1 cycle): acc_start=1 → RUN.
- RUN:
  - Each fire increments its counter; all three may increment in the same cycle.
  - acc_done sets a sticky flag.
  - Exit when the flag is set and all counters equal their descriptor values.
  - Exit to NEXT may occur in the same cycle as the final fire/acc_done; that event is counted.
- Overflow: a fire while its counter already equals its descriptor value → ERR. This applies in RUN, and also to fires arriving in CMD/KICK, which are counted.
- Watchdog: counts RUN cycles with no fire and no acc_done; resets on any activity. Reaching all-ones → ERR.
- NEXT:
  - cur_layer+1 == num_layers → DONE.
  - otherwise cur_layer++ → LOAD.
- DONE (1 cycle): done=1, busy=0 next → IDLE.
- ERR (1 cycle): error=1 (sticky), cur_layer holds the failing layer, busy=0 → IDLE. error clears only on the next accepted start or rst.
- rst mid-run: synchronous abort to IDLE next edge. No done pulse; dma_cmd_valid drops immediately.
- Widths: counters CNT_W, no wrap (overflow detected before wrap). Watchdog TIMEOUT_W saturating compare.

Decomposition:
- Package cnn_sched_pkg: state enum (IDLE, LOAD, CMD, KICK, RUN, NEXT, DONE, ERR); DMA select constants SEL_IFM=0, SEL_WGT=1, SEL_OFM=2; descriptor struct {ifm_beats, wgt_beats, ofm_beats}.
- One sub-module, cnn_desc_table: MAX_LAYERS x 3*CNT_W synchronous-write, synchronous-read RAM.
- FSM, counters and watchdog stay in the top.

Test Plan:
- 2 layers {ifm 4, wgt 2, ofm 3} and {8,0,1}; DMA ready immediately; model fires beats, then acc_done.
  - Required: commands (0,4),(1,2),(2,3), then (0,8),(2,1) with WGT skipped.
  - Exactly two acc_start pulses; one done pulse; error=0.
- acc_done arrives before the last OFM beat → stays in RUN; NEXT only on the cycle of the 3rd ofm_fire.
- Extra 5th ifm_fire with ifm_beats=4 → ERR; error=1; cur_layer=failing layer; busy=0; no done.
- No activity after acc_start with TIMEOUT_W=4 → error asserted 15 RUN cycles later.
- start with num_layers=0 → done pulse next cycle; no acc_start; no dma_cmd_valid.
- dma_cmd_ready held low 10 cycles, then rst asserted → cmd_valid stays high with stable len until the reset edge. After reset all outputs 0; a cfg write then succeeds.
